// File: rtl/signal_replay_pkg.sv
// rtl/signal_replay_pkg.sv - symbol encoding constants shared by signal capture and replay
package signal_pkg;
  localparam int DAQT_SIGNAL_DATA = 64;
  localparam int NSLOTS           = 7;
  localparam int SLOT_BITS        = 3;

  localparam logic       PFX_SHORT = 1'b0;
  localparam logic [1:0] PFX_MID   = 2'b10;
  localparam logic [2:0] PFX_LONG  = 3'b110;

  typedef enum logic { SYM_LIT, SYM_RUN } sym_kind_t;
  typedef enum logic { P_IDLE, P_PLAY } play_state_t;
endpackage

// File: rtl/signal_replay_if.sv
// rtl/signal_replay_if.sv - packed bitstream word handshake into the replay block
interface signal_replay_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/signal_replay_bitbuf.sv
// rtl/signal_replay_bitbuf.sv - 64-bit MSB-first bit buffer with consume and skip-append
module signal_bitbuf
  import signal_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        consume,
  input  logic [5:0]  consume_n,
  input  logic        append,
  input  logic [31:0] word,
  input  logic [4:0]  skip,
  output logic [31:0] peek,
  output logic [6:0]  count
);
  logic [DAQT_SIGNAL_DATA-1:0] data_q;
  logic [DAQT_SIGNAL_DATA-1:0] base;
  logic [DAQT_SIGNAL_DATA-1:0] fresh;
  logic [6:0]                  base_cnt;
  logic [31:0]                 word_sk;

  // Consume happens before append so a word lands right behind the surviving bits.
  always_comb begin
    base     = data_q;
    base_cnt = count;
    if (flush) begin
      base     = '0;
      base_cnt = '0;
    end else if (consume) begin
      base     = data_q << consume_n;
      base_cnt = count - {1'b0, consume_n};
    end
    word_sk = word << skip;
    fresh   = {word_sk, 32'd0} >> base_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      count  <= '0;
    end else if (append) begin
      data_q <= base | fresh;
      count  <= base_cnt + 7'd32 - {2'b00, skip};
    end else begin
      data_q <= base;
      count  <= base_cnt;
    end
  end

  assign peek = data_q[DAQT_SIGNAL_DATA-1 -: 32];
endmodule

// File: rtl/signal_replay.sv
// rtl/signal_replay.sv - replays a captured signal from its LRU/RLE-coded bitstream
module signal_replay
  import signal_pkg::*;
#(
  parameter int SIG_WIDTH = 18,
  parameter int RLE_BITS  = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 sync,
  input  logic [4:0]           sync_skip,
  signal_replay_if.slave       in_if,
  output logic [SIG_WIDTH-1:0] sig_out,
  output logic                 sig_valid,
  output logic                 err_underrun,
  output logic                 err_proto
);
  logic [31:0]          peek;
  logic [6:0]           count;
  logic                 accept, consume, emit;
  logic [4:0]           eff_skip, skip_reg;
  logic                 skip_pend;
  logic [5:0]           sym_len;
  logic                 sym_ok, slot_live, dec_bad;
  sym_kind_t            dec_kind;
  logic [2:0]           dec_slot;
  logic [RLE_BITS-1:0]  dec_cnt;
  logic [SIG_WIDTH-1:0] dec_val;
  play_state_t          state;
  logic [2:0]           play_slot;
  logic [RLE_BITS-1:0]  play_rem;
  logic                 had_sample;
  logic [SIG_WIDTH-1:0] entry [NSLOTS];
  logic [SIG_WIDTH-1:0] entry_nx [NSLOTS];
  logic [NSLOTS-1:0]    valid, valid_nx;
  logic                 acc_lit;
  logic [2:0]           acc_slot;
  logic [SIG_WIDTH-1:0] acc_out;

  assign in_if.in_ready = enable && !rst && (count <= 7'd32);
  assign accept   = in_if.in_valid && in_if.in_ready;
  assign eff_skip = sync ? sync_skip : (skip_pend ? skip_reg : 5'd0);
  assign consume  = !rst && !sync && enable && (state == P_IDLE) && sym_ok;
  assign emit     = (state == P_PLAY) || (sym_ok && !dec_bad);

  signal_bitbuf u_bitbuf (
    .clk       (clk),
    .rst       (rst),
    .flush     (sync),
    .consume   (consume),
    .consume_n (sym_len),
    .append    (accept),
    .word      (in_if.in_data),
    .skip      (eff_skip),
    .peek      (peek),
    .count     (count)
  );

  // Bits past count read as zero, so a partial symbol always looks longer than what is held.
  always_comb begin
    dec_slot  = peek[31:29];
    dec_kind  = SYM_RUN;
    dec_val   = SIG_WIDTH'(peek[28:0] >> (29 - SIG_WIDTH));
    dec_cnt   = '0;
    dec_bad   = 1'b0;
    slot_live = 1'b0;
    if (dec_slot == 3'd0) begin
      dec_kind = SYM_LIT;
      dec_cnt  = RLE_BITS'(1);
      sym_len  = 6'(SLOT_BITS + SIG_WIDTH);
    end else if (peek[28] == PFX_SHORT) begin
      dec_cnt = RLE_BITS'(peek[27:24]);
      sym_len = 6'd8;
    end else if (peek[28:27] == PFX_MID) begin
      dec_cnt = RLE_BITS'(peek[26:19]);
      sym_len = 6'd13;
    end else if (peek[28:26] == PFX_LONG) begin
      dec_cnt = RLE_BITS'(peek[25:0] >> (26 - RLE_BITS));
      sym_len = 6'(SLOT_BITS + 3 + RLE_BITS);
    end else begin
      sym_len = 6'd6;
      dec_bad = 1'b1;
    end
    for (int i = 0; i < NSLOTS; i++)
      if (int'(dec_slot) == i + 1) slot_live = valid[i];
    if (dec_kind == SYM_RUN && (dec_cnt == '0 || !slot_live)) dec_bad = 1'b1;
    sym_ok = ({1'b0, sym_len} <= count);
  end

  // One LRU access per emitted sample; the accessed entry moves to the front.
  always_comb begin
    acc_lit  = (state == P_IDLE) && (dec_kind == SYM_LIT);
    acc_slot = (state == P_PLAY) ? play_slot : dec_slot;
    acc_out  = dec_val;
    for (int i = 0; i < NSLOTS; i++)
      if (!acc_lit && int'(acc_slot) == i + 1) acc_out = entry[i];
    entry_nx = entry;
    valid_nx = valid;
    if (acc_lit) begin
      for (int i = NSLOTS - 1; i > 0; i--) entry_nx[i] = entry[i-1];
      valid_nx = {valid[NSLOTS-2:0], 1'b1};
    end else begin
      for (int i = 1; i < NSLOTS; i++)
        if (i < int'(acc_slot)) entry_nx[i] = entry[i-1];
    end
    entry_nx[0] = acc_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= P_IDLE;
      play_slot    <= '0;
      play_rem     <= '0;
      sig_out      <= '0;
      sig_valid    <= 1'b0;
      err_underrun <= 1'b0;
      err_proto    <= 1'b0;
      had_sample   <= 1'b0;
      valid        <= '0;
      entry        <= '{default: '0};
      skip_pend    <= 1'b0;
      skip_reg     <= '0;
    end else begin
      if (sync) begin
        skip_pend <= !accept;
        skip_reg  <= sync_skip;
      end else if (accept) begin
        skip_pend <= 1'b0;
      end

      if (sync) begin
        state      <= P_IDLE;
        valid      <= '0;
        sig_valid  <= 1'b0;
        had_sample <= 1'b0;
      end else if (enable) begin
        if (emit) begin
          sig_out    <= acc_out;
          sig_valid  <= 1'b1;
          entry      <= entry_nx;
          valid      <= valid_nx;
          had_sample <= 1'b1;
        end else begin
          sig_valid <= 1'b0;
        end

        if (state == P_PLAY) begin
          play_rem <= play_rem - RLE_BITS'(1);
          if (play_rem == RLE_BITS'(1)) state <= P_IDLE;
        end else if (sym_ok) begin
          if (dec_bad) begin
            err_proto <= 1'b1;
          end else begin
            play_slot <= dec_slot;
            play_rem  <= dec_cnt - RLE_BITS'(1);
            if (dec_cnt > RLE_BITS'(1)) state <= P_PLAY;
          end
        end else if (had_sample) begin
          err_underrun <= 1'b1;
        end
      end
    end
  end
endmodule
